// File: rtl/ibex_pkg.sv
// Shared ibex types: multdiv operator encoding and the multdiv arbiter FSM states.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        MDARB_IDLE = 2'd0,
        MDARB_BUSY = 2'd1,
        MDARB_RESP = 2'd2
    } mdarb_state_e;

    // Operation held stable towards the slow unit for the whole of BUSY.
    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
    } md_req_t;

endpackage

// File: rtl/ibex_rr_arbiter.sv
// Round-robin arbiter: the first set request at or after ptr (wrapping) wins.
module ibex_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     idx,
    output logic               valid
);

    int j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/ibex_multdiv_arbiter.sv
// Shares one ibex_multdiv_slow unit between NUM_REQ requesters with round-robin grant.
// The unit cannot be flushed, so a killed op runs to completion and its result is dropped.
module ibex_multdiv_arbiter import ibex_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = $clog2(NUM_REQ),
    parameter int TIMEOUT = 48
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [2*NUM_REQ-1:0]   req_operator_i,
    input  logic [2*NUM_REQ-1:0]   req_signed_mode_i,
    input  logic [32*NUM_REQ-1:0]  req_op_a_i,
    input  logic [32*NUM_REQ-1:0]  req_op_b_i,
    input  logic [NUM_REQ-1:0]     kill_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [IDW-1:0]         rsp_id_o,
    output logic [31:0]            rsp_result_o,
    output logic                   md_mult_en_o,
    output logic                   md_div_en_o,
    output logic [1:0]             md_operator_o,
    output logic [1:0]             md_signed_mode_o,
    output logic [31:0]            md_op_a_o,
    output logic [31:0]            md_op_b_o,
    input  logic                   md_valid_i,
    input  logic [31:0]            md_result_i,
    output logic                   err_timeout_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_M1 = CW'(TIMEOUT - 1);

    mdarb_state_e          state_q, state_d;
    logic [IDW-1:0]        ptr_q, id_q, g_idx;
    logic [NUM_REQ-1:0]    g_onehot;
    logic                  g_valid;
    md_req_t               req_q, req_sel;
    logic                  killed_q, kill_own, err_q;
    logic [CW-1:0]         cnt_q;
    logic [31:0]           result_q;

    ibex_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
        .req   (req_valid_i),
        .ptr   (ptr_q),
        .gnt   (g_onehot),
        .idx   (g_idx),
        .valid (g_valid)
    );

    always_comb begin
        req_sel.op   = req_operator_i[2*int'(g_idx) +: 2];
        req_sel.mode = req_signed_mode_i[2*int'(g_idx) +: 2];
        req_sel.a    = req_op_a_i[32*int'(g_idx) +: 32];
        req_sel.b    = req_op_b_i[32*int'(g_idx) +: 32];
    end

    assign kill_own = kill_i[id_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= MDARB_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MDARB_IDLE: if (g_valid) state_d = MDARB_BUSY;
            // A kill landing together with md_valid_i still discards the result.
            MDARB_BUSY: if (md_valid_i) state_d = (killed_q || kill_own) ? MDARB_IDLE : MDARB_RESP;
            MDARB_RESP: if (rsp_ready_i || kill_own) state_d = MDARB_IDLE;
            default:    state_d = MDARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = '0;
        md_mult_en_o = 1'b0;
        md_div_en_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        case (state_q)
            MDARB_IDLE: if (!rst_i) req_ready_o = g_onehot;
            MDARB_BUSY: begin
                md_mult_en_o = ~req_q.op[1];
                md_div_en_o  = req_q.op[1];
            end
            MDARB_RESP: rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q    <= '0;
            id_q     <= '0;
            req_q    <= '0;
            killed_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                MDARB_IDLE: if (g_valid) begin
                    req_q    <= req_sel;
                    id_q     <= g_idx;
                    ptr_q    <= (g_idx == IDW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
                    killed_q <= 1'b0;
                    cnt_q    <= '0;
                end
                MDARB_BUSY: begin
                    if (kill_own) killed_q <= 1'b1;
                    // Counter saturates; the flag stays set until reset.
                    if (cnt_q == TO_M1) err_q <= 1'b1;
                    else                cnt_q <= cnt_q + 1'b1;
                    if (md_valid_i) result_q <= md_result_i;
                end
                default: ;
            endcase
        end
    end

    assign md_operator_o    = req_q.op;
    assign md_signed_mode_o = req_q.mode;
    assign md_op_a_o        = req_q.a;
    assign md_op_b_o        = req_q.b;
    assign rsp_id_o         = id_q;
    assign rsp_result_o     = result_q;
    assign err_timeout_o    = err_q;

endmodule
